// File: rtl/xnor_popcount_seq.sv
// xnor_popcount_seq
//   Sequencer/accumulator for a binary-neural-network neuron. Streams an
//   xnor-popcount dot product through one CHUNK_W-wide popcount datapath,
//   accumulates partial counts over a configurable number of beats, compares
//   the total against a signed threshold and returns it over valid/ready.
//
//   Optional feature macro: XNOR_POPCOUNT_SEQ_BIPOLAR_EN
//     defined   : out_sum = 2*acc - beats*CHUNK_W (signed +/-1 dot product)
//     undefined : out_sum = {1'b0, acc}
//
//   Ports:
//     clk         clock, rising edge
//     rst         asynchronous active-high reset
//     cfg_beats   beats per vector, sampled on the first beat of a vector
//     cfg_thresh  signed threshold, sampled with cfg_beats
//     in_valid    beat valid            in_ready   beat accept
//     xi, wi      activation / weight chunk
//     out_valid   result valid          out_ready  result accept
//     out_sum     accumulated result (signed container)
//     out_bit     out_sum >= threshold
//     busy        high in any state other than IDLE
//     err_cfg     sticky illegal-configuration flag
module xnor_popcount_seq #(
    parameter int CHUNK_W   = 64,
    parameter int CNT_W     = 7,
    parameter int MAX_BEATS = 16,
    parameter int BEAT_W    = 5,
    parameter int ACC_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BEAT_W-1:0]  cfg_beats,
    input  logic [ACC_W:0]     cfg_thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] xi,
    input  logic [CHUNK_W-1:0] wi,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W:0]     out_sum,
    output logic               out_bit,
    output logic               busy,
    output logic               err_cfg
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_t;

    state_t             st, st_next;
    logic [BEAT_W-1:0]  beats_l, beat_cnt, beats_clamped;
    logic [ACC_W:0]     thresh_l;
    logic               cfg_bad;
    logic               beat_xfer;
    logic [CHUNK_W-1:0] match_bits;
    logic [CNT_W-1:0]   pc_comb, pc_r;
    logic               pc_v, pc_first;
    logic [ACC_W-1:0]   acc, acc_next;
    logic [ACC_W:0]     sum_val;

    assign beat_xfer  = in_valid && in_ready;
    assign busy       = (st != IDLE);
    assign match_bits = xi ~^ wi;

    always_comb begin
        pc_comb = '0;
        for (int unsigned i = 0; i < CHUNK_W; i++)
            pc_comb = pc_comb + CNT_W'(match_bits[i]);
    end

    // Zero and oversize beat counts are coerced into the legal range.
    always_comb begin
        cfg_bad       = 1'b0;
        beats_clamped = cfg_beats;
        if (cfg_beats == '0) begin
            cfg_bad       = 1'b1;
            beats_clamped = BEAT_W'(1);
        end else if (cfg_beats > BEAT_W'(MAX_BEATS)) begin
            cfg_bad       = 1'b1;
            beats_clamped = BEAT_W'(MAX_BEATS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_next;
    end

    always_comb begin
        st_next   = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    st_next = (beats_clamped == BEAT_W'(1)) ? FLUSH : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt + BEAT_W'(1) == beats_l))
                    st_next = FLUSH;
            end
            FLUSH: st_next = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) st_next = IDLE;
            end
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_l  <= '0;
            thresh_l <= '0;
            beat_cnt <= '0;
            err_cfg  <= 1'b0;
        end else if (st == IDLE && beat_xfer) begin
            beats_l  <= beats_clamped;
            thresh_l <= cfg_thresh;
            beat_cnt <= BEAT_W'(1);
            if (cfg_bad) err_cfg <= 1'b1;
        end else if (st == RUN && beat_xfer) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // The first flag rides with pc_v so the accumulator restarts per vector.
    assign acc_next = (pc_first ? '0 : acc) + ACC_W'(pc_r);

    // The result is captured from acc_next so the final beat, absorbed on
    // the FLUSH->HOLD edge, is already included.
`ifdef XNOR_POPCOUNT_SEQ_BIPOLAR_EN
    assign sum_val = {acc_next, 1'b0} - (ACC_W+1)'(int'(beats_l) * CHUNK_W);
`else
    assign sum_val = {1'b0, acc_next};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= '0;
            pc_v     <= 1'b0;
            pc_first <= 1'b0;
            acc      <= '0;
            out_sum  <= '0;
            out_bit  <= 1'b0;
        end else begin
            pc_v <= beat_xfer;
            if (beat_xfer) begin
                pc_r     <= pc_comb;
                pc_first <= (st == IDLE);
            end
            if (pc_v) acc <= acc_next;
            if (st == FLUSH) begin
                out_sum <= sum_val;
                out_bit <= ($signed(sum_val) >= $signed(thresh_l));
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_seq.sv
module tb_xnor_popcount_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_beats;
    logic [11:0] cfg_thresh;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] xi, wi;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic        out_bit;
    logic        busy;
    logic        err_cfg;

    int checks   = 0;
    int failures = 0;

    xnor_popcount_seq #(
        .CHUNK_W(64), .CNT_W(7), .MAX_BEATS(16), .BEAT_W(5), .ACC_W(11)
    ) dut (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .xi(xi), .wi(wi),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_bit(out_bit), .busy(busy), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // xi with wi=0 such that popcount(xi ~^ wi) == k
    function automatic logic [63:0] pat(input int k);
        logic [63:0] m;
        m = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
        return ~m;
    endfunction

    function automatic int model_sum(input int acc, input int beats);
`ifdef XNOR_POPCOUNT_SEQ_BIPOLAR_EN
        return 2 * acc - beats * 64;
`else
        return acc;
`endif
    endfunction

    function automatic logic [11:0] exp_sum(input int acc, input int beats);
        return 12'(model_sum(acc, beats));
    endfunction

    function automatic logic exp_bit(input int acc, input int beats, input int thresh);
        return model_sum(acc, beats) >= thresh;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_beat(input logic [63:0] x, input logic [63:0] w);
        int n = 0;
        xi = x; wi = w; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("busy_after_take", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [63:0] same;
        logic [11:0] held;
        logic [63:0] vx[12];
        int exp_acc[3];
        int idx, cyc, last, nres;
        logic accepted;

        same = 64'hDEAD_BEEF_0123_ABCD;
        rst = 1'b1; cfg_beats = '0; cfg_thresh = '0;
        in_valid = 1'b0; out_ready = 1'b0; xi = '0; wi = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cfg", 32'(err_cfg), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 4 beats, xi==wi, thresh 128
        cfg_beats = 5'd4; cfg_thresh = 12'd128;
        for (int b = 0; b < 4; b++) send_beat(same, same);
        chk("t1_valid_after_last", 32'(out_valid), 32'd0);
        chk("t1_flush_in_ready", 32'(in_ready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_valid_latency", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'(exp_sum(256, 4)));
        chk("t1_bit", 32'(out_bit), 32'(exp_bit(256, 4, 128)));
        take_result();

        // 2 beats, xi = ~wi, thresh 1
        cfg_beats = 5'd2; cfg_thresh = 12'd1;
        for (int b = 0; b < 2; b++) send_beat(~same, same);
        wait_result();
        chk("t2_sum", 32'(out_sum), 32'(exp_sum(0, 2)));
        chk("t2_bit", 32'(out_bit), 32'(exp_bit(0, 2, 1)));
        take_result();

        // 3 beats, popcounts 10/20/30 with gaps, out_ready held low
        cfg_beats = 5'd3; cfg_thresh = 12'd60;
        send_beat(pat(10), '0);
        @(negedge clk);
        cfg_beats = 5'd9; cfg_thresh = 12'd0;   // ignored mid-vector
        send_beat(pat(20), '0);
        repeat (3) @(negedge clk);
        send_beat(pat(30), '0);
        wait_result();
        held = out_sum;
        chk("t3_sum", 32'(out_sum), 32'(exp_sum(60, 3)));
        chk("t3_bit", 32'(out_bit), 32'(exp_bit(60, 3, 60)));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_stable", 32'(out_sum), 32'(held));
            chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
        end
        take_result();
        @(negedge clk);
        chk("t3_single_xfer", 32'(out_valid), 32'd0);
        chk("t3_no_err", 32'(err_cfg), 32'd0);

        // cfg_beats = 0 -> one beat, err_cfg
        cfg_beats = 5'd0; cfg_thresh = 12'd0;
        send_beat(same, same);
        @(negedge clk);
        chk("t4_zero_valid", 32'(out_valid), 32'd1);
        chk("t4_zero_sum", 32'(out_sum), 32'(exp_sum(64, 1)));
        chk("t4_zero_err", 32'(err_cfg), 32'd1);
        take_result();
        rst = 1'b1; #1;
        chk("t4_err_cleared", 32'(err_cfg), 32'd0);
        @(negedge clk); rst = 1'b0;

        // cfg_beats = 20 -> clamped to 16
        cfg_beats = 5'd20; cfg_thresh = 12'd1000;
        for (int b = 0; b < 15; b++) send_beat(same, same);
        chk("t4_clamp_still_run", 32'(in_ready), 32'd1);
        send_beat(same, same);
        chk("t4_clamp_flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t4_clamp_valid", 32'(out_valid), 32'd1);
        chk("t4_clamp_sum", 32'(out_sum), 32'(exp_sum(1024, 16)));
        chk("t4_clamp_bit", 32'(out_bit), 32'(exp_bit(1024, 16, 1000)));
        chk("t4_clamp_err", 32'(err_cfg), 32'd1);
        take_result();

        // Reset mid-vector
        cfg_beats = 5'd4; cfg_thresh = 12'd0;
        send_beat(same, same);
        send_beat(same, same);
        rst = 1'b1; #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_sum", 32'(out_sum), 32'd0);
        chk("t5_rst_err", 32'(err_cfg), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        cfg_beats = 5'd1;
        send_beat(same, same);
        wait_result();
        chk("t5_clean_sum", 32'(out_sum), 32'(exp_sum(64, 1)));
        take_result();

        // Three back-to-back 4-beat vectors
        cfg_beats = 5'd4; cfg_thresh = 12'd100;
        for (int b = 0; b < 4; b++) vx[b] = pat(64);
        vx[4] = pat(1); vx[5] = pat(2); vx[6] = pat(3); vx[7] = pat(4);
        vx[8] = pat(0); vx[9] = pat(0); vx[10] = pat(0); vx[11] = pat(5);
        exp_acc[0] = 256; exp_acc[1] = 10; exp_acc[2] = 5;
        out_ready = 1'b1;
        idx = 0; cyc = 0; last = -1; nres = 0;
        while (nres < 3 && cyc < 100) begin
            if (idx < 12) begin in_valid = 1'b1; xi = vx[idx]; wi = '0; end
            else in_valid = 1'b0;
            if (out_valid) begin
                chk("t6_sum", 32'(out_sum), 32'(exp_sum(exp_acc[nres], 4)));
                chk("t6_bit", 32'(out_bit), 32'(exp_bit(exp_acc[nres], 4, 100)));
                if (last >= 0) chk("t6_interval", 32'(cyc - last), 32'd6);
                last = cyc;
                nres++;
            end
            accepted = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (accepted) idx++;
        end
        in_valid = 1'b0;
        chk("t6_result_count", 32'(nres), 32'd3);
        @(negedge clk);
        chk("t6_idle_after", 32'(busy), 32'd0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
